matrix_mult_sequencer: RTL and testbench
========================================

// Module: matrix_mult_sequencer
// PURPOSE
//  Master sequencer sitting directly upstream of the data memory unit.
//  On a start pulse it reads NxN matrices A and B (row-major, 16-bit words) over the
//  memory port, computes C = A*B with an internal multiply-accumulate, and writes C
//  back to memory. It is the sole driver of the memory address/data/enable inputs.
// PARAMETERS
//  N       3    matrix dimension (N>=1, N*N*3+C_BASE must fit in 16-bit address)
//  A_BASE  0    word address of A[0][0]
//  B_BASE  9    word address of B[0][0]
//  C_BASE  18   word address of C[0][0]
//  ACC_W   40   accumulator width (>= 32 + clog2(N))
// PORTS
//  clk               in   1   rising-edge clock
//  rst_n             in   1   asynchronous active-low reset
//  start             in   1   1-cycle request; sampled only in IDLE
//  busy              out  1   high from cycle after accepted start through last write
//  done              out  1   1-cycle pulse after final C write
//  ovf               out  1   sticky: some C element exceeded 16 bits; cleared on start
//  mem_address       out  16  word address to data memory
//  mem_write_data    out  16  write data to data memory
//  mem_write_enable  out  1   write strobe (memory writes on clk rise)
//  mem_read_enable   out  1   read strobe (memory read is combinational)
//  mem_read_data     in   16  combinational read data from data memory
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; busy=done=ovf=0; mem_* outputs all 0; counters 0.
//  - All arithmetic unsigned. Addresses: A[i][k]=A_BASE+i*N+k, B[k][j]=B_BASE+k*N+j,
//    C[i][j]=C_BASE+i*N+j, computed mod 2^16.
//  - FSM states and transitions:
//    IDLE : outputs idle; start=1 -> clear acc, i=j=k=0, ovf=0 -> RD_A.
//    RD_A : mem_address=A[i][k], mem_read_enable=1; latch mem_read_data into a_reg -> RD_B.
//    RD_B : mem_address=B[k][j], mem_read_enable=1; acc += a_reg*mem_read_data (same edge);
//           k==N-1 -> WR, else k++ -> RD_A.
//    WR   : mem_address=C[i][j], mem_write_enable=1, mem_write_data=acc[15:0] (see CONFIG);
//           acc[ACC_W-1:16]!=0 sets ovf; acc<=0, k<=0; advance j, wrap j to 0 and i++;
//           i==N-1 && j==N-1 -> DONE, else -> RD_A.
//    DONE : done=1, busy=0 for one cycle -> IDLE.
//  - mem_read_enable and mem_write_enable are never high in the same cycle; outside
//    RD_A/RD_B/WR, mem_address=0 and mem_write_data=0.
//  - mem_* outputs are combinational decodes of registered state/counters (glitch-free
//    at clk edge); the acc value written in WR is the registered value.
//  - Latency: 2 cycles per product, 1 write per element; total N*N*(2N+1) busy cycles
//    (63 for N=3), done asserted on the next cycle.
//  - start while busy or in DONE: ignored, no effect on the computation.
//  - start in the same cycle as done: ignored (start is sampled only in IDLE).
//  - rst_n asserted mid-operation: immediate return to IDLE; C elements already written
//    stay in memory, partial acc is discarded, no done pulse.
//  - In-place overlap of C with A/B is not protected; results are then undefined.
// CONFIGURATION
//  SAT_WRITE_EN defined  : WR writes 16'hFFFF when acc[ACC_W-1:16]!=0, else acc[15:0].
//  SAT_WRITE_EN undefined: WR always writes acc[15:0] (wrap). ovf behaves identically
//                          in both builds.
// TESTING
//  1 reset: rst_n=0 with start=1 -> busy=done=ovf=0, all mem_* outputs 0.
//  2 A=B=[[1,2,3],[1,2,3],[1,2,3]] at 0/9, pulse start -> mem[18..26]=6,12,18 x3 rows;
//    done exactly 64 cycles after start edge; ovf=0.
//  3 A=identity, B=[[1..9]] -> C equals B; addresses in RD_A/RD_B/WR match formulas
//    per cycle; no cycle has both mem enables high.
//  4 A=B=all 16'hFFFF -> each C word=16'h0003 (wrap build) or 16'hFFFF (SAT_WRITE_EN);
//    ovf=1 after first WR, stays 1 until the next start.
//  5 start pulses at cycles 5 and 30 of a run -> single run, done once, result as in 2.
//  6 rst_n low at cycle 20, then start -> fresh run; mem[18..26] correct; first
//    element(s) rewritten identically; one done pulse.

Source files
------------

// File: rtl/matrix_mult_sequencer.sv
// matrix_mult_sequencer
//   Master sequencer upstream of the data memory. On a start pulse it reads the NxN
//   matrices A and B (row-major, 16-bit words), computes C = A*B with one
//   multiply-accumulate per two cycles, and writes each C element back to memory.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               1-cycle request, sampled only in idle
//   busy                high while reading/accumulating/writing
//   done                1-cycle pulse after the final C write
//   ovf                 sticky: some C element exceeded 16 bits; cleared on start
//   mem_address         word address to data memory
//   mem_write_data      write data
//   mem_write_enable    write strobe (memory writes on clk rise)
//   mem_read_enable     read strobe (memory read is combinational)
//   mem_read_data       combinational read data
//
// Build option
//   SAT_WRITE_EN        when defined, an element that overflows 16 bits is written as
//                       16'hFFFF instead of its low 16 bits. ovf is identical either way.
module matrix_mult_sequencer #(
  parameter int unsigned N      = 3,
  parameter int unsigned A_BASE = 0,
  parameter int unsigned B_BASE = 9,
  parameter int unsigned C_BASE = 18,
  parameter int unsigned ACC_W  = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [15:0] mem_address,
  output logic [15:0] mem_write_data,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [15:0] mem_read_data
);

  localparam logic [15:0] NW      = 16'(N);
  localparam logic [15:0] LastIdx = 16'(N - 1);
  localparam logic [15:0] ABase   = 16'(A_BASE);
  localparam logic [15:0] BBase   = 16'(B_BASE);
  localparam logic [15:0] CBase   = 16'(C_BASE);

  typedef enum logic [2:0] {StIdle, StRdA, StRdB, StWr, StDone} state_e;

  state_e             state_q, state_d;
  logic [15:0]        i_q, i_d, j_q, j_d, k_q, k_d;
  logic [15:0]        a_q, a_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;

  logic [31:0]        prod;
  logic               acc_hi_nz;

  assign prod      = {16'b0, a_q} * {16'b0, mem_read_data};
  assign acc_hi_nz = |acc_q[ACC_W-1:16];
  assign ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    a_d     = a_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = StRdA;
        end
      end
      StRdA: begin
        a_d     = mem_read_data;
        state_d = StRdB;
      end
      StRdB: begin
        acc_d = acc_q + ACC_W'(prod);
        if (k_q == LastIdx) begin
          state_d = StWr;
        end else begin
          k_d     = k_q + 16'd1;
          state_d = StRdA;
        end
      end
      StWr: begin
        if (acc_hi_nz) ovf_d = 1'b1;
        acc_d = '0;
        k_d   = '0;
        if (j_q == LastIdx) begin
          j_d = '0;
          i_d = (i_q == LastIdx) ? 16'd0 : i_q + 16'd1;
        end else begin
          j_d = j_q + 16'd1;
        end
        state_d = (i_q == LastIdx && j_q == LastIdx) ? StDone : StRdA;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory-port and status decode from registered state only.
  always_comb begin
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    unique case (state_q)
      StRdA: begin
        mem_address     = ABase + i_q * NW + k_q;
        mem_read_enable = 1'b1;
        busy            = 1'b1;
      end
      StRdB: begin
        mem_address     = BBase + k_q * NW + j_q;
        mem_read_enable = 1'b1;
        busy            = 1'b1;
      end
      StWr: begin
        mem_address      = CBase + i_q * NW + j_q;
        mem_write_enable = 1'b1;
        busy             = 1'b1;
`ifdef SAT_WRITE_EN
        mem_write_data   = acc_hi_nz ? 16'hFFFF : acc_q[15:0];
`else
        mem_write_data   = acc_q[15:0];
`endif
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
module tb_matrix_mult_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy, done, ovf;
  logic [15:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable;

  logic [15:0] mem [65536];

  int n_cmp = 0;
  int n_err = 0;

  // Per-run observations.
  int done_cyc, n_done, n_busy, both_hi;
  logic ovf_c6, ovf_c8;

  matrix_mult_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .ovf              (ovf),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_read_data    (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: combinational read, write on clk rise.
  assign mem_read_data = mem_read_enable ? mem[mem_address] : 16'h0;
  always @(posedge clk) if (mem_write_enable) mem[mem_address] <= mem_write_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] a [9], input logic [15:0] b [9]);
    for (int n = 0; n < 9; n++) begin
      mem[n]      = a[n];
      mem[9 + n]  = b[n];
      mem[18 + n] = 16'h0;
    end
  endtask

  task automatic check_c(input string tag, input logic [15:0] c [9]);
    for (int n = 0; n < 9; n++) check_eq($sformatf("%s_c%0d", tag, n), 64'(mem[18 + n]), 64'(c[n]));
  endtask

  task automatic check_run(input string tag);
    check_eq({tag, "_done_cyc"}, 64'(done_cyc), 64'd64);
    check_eq({tag, "_n_done"}, 64'(n_done), 64'd1);
    check_eq({tag, "_n_busy"}, 64'(n_busy), 64'd63);
    check_eq({tag, "_both_en"}, 64'(both_hi), 64'd0);
  endtask

  // Cycle c is the cycle following the c-th rising edge, counting the start edge as 1.
  // p1..p3: cycles during which start is held high again; chk_addr: per-cycle port check.
  task automatic run(input int p1, input int p2, input int p3, input bit chk_addr);
    int e, p, ii, jj, kk;
    logic [15:0] ea;
    done_cyc = 0; n_done = 0; n_busy = 0; both_hi = 0;
    ovf_c6 = 1'bx; ovf_c8 = 1'bx;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 90; c++) begin
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (busy) n_busy++;
      if (mem_read_enable && mem_write_enable) both_hi++;
      if (c == 6) ovf_c6 = ovf;
      if (c == 8) ovf_c8 = ovf;
      if (chk_addr && c <= 63) begin
        e  = (c - 1) / 7;
        p  = (c - 1) % 7;
        ii = e / 3;
        jj = e % 3;
        kk = p / 2;
        if (p == 6)          ea = 16'(18 + e);
        else if (p % 2 == 0) ea = 16'(ii * 3 + kk);
        else                 ea = 16'(9 + kk * 3 + jj);
        check_eq($sformatf("addr_c%0d", c), 64'(mem_address), 64'(ea));
        check_eq($sformatf("we_c%0d", c), 64'(mem_write_enable), 64'(p == 6));
        check_eq($sformatf("re_c%0d", c), 64'(mem_read_enable), 64'(p != 6));
      end
      start = (c == p1 || c == p2 || c == p3);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  logic [15:0] a123 [9] = '{1, 2, 3, 1, 2, 3, 1, 2, 3};
  logic [15:0] c123 [9] = '{6, 12, 18, 6, 12, 18, 6, 12, 18};
  logic [15:0] ident [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  logic [15:0] b19 [9]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  logic [15:0] allf [9] = '{default: 16'hFFFF};
`ifdef SAT_WRITE_EN
  logic [15:0] cff [9]  = '{default: 16'hFFFF};
`else
  logic [15:0] cff [9]  = '{default: 16'h0003};
`endif

  initial begin
    // Reset with start held high.
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_ovf", 64'(ovf), 64'd0);
    check_eq("rst_addr", 64'(mem_address), 64'd0);
    check_eq("rst_wdata", 64'(mem_write_data), 64'd0);
    check_eq("rst_we", 64'(mem_write_enable), 64'd0);
    check_eq("rst_re", 64'(mem_read_enable), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy_held", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Rows of [1,2,3] times themselves.
    load(a123, a123);
    run(0, 0, 0, 1'b0);
    check_run("t2");
    check_c("t2", c123);
    check_eq("t2_ovf", 64'(ovf), 64'd0);

    // Identity times 1..9 with per-cycle address/strobe checks.
    load(ident, b19);
    run(0, 0, 0, 1'b1);
    check_run("t3");
    check_c("t3", b19);

    // All-ones operands overflow every element.
    load(allf, allf);
    run(0, 0, 0, 1'b0);
    check_run("t4");
    check_c("t4", cff);
    check_eq("t4_ovf_c6", 64'(ovf_c6), 64'd0);
    check_eq("t4_ovf_c8", 64'(ovf_c8), 64'd1);
    check_eq("t4_ovf_end", 64'(ovf), 64'd1);

    // Extra start pulses while busy and during done are ignored; ovf cleared by start.
    load(a123, a123);
    run(5, 30, 64, 1'b0);
    check_run("t5");
    check_c("t5", c123);
    check_eq("t5_ovf_c6", 64'(ovf_c6), 64'd0);
    check_eq("t5_busy_after", 64'(busy), 64'd0);

    // Abort at cycle 20, then a fresh run.
    load(a123, a123);
    n_done = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c < 20; c++) begin
      if (done) n_done++;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_eq("t6_abort_busy", 64'(busy), 64'd0);
    check_eq("t6_abort_we", 64'(mem_write_enable), 64'd0);
    check_eq("t6_abort_done", 64'(n_done), 64'd0);
    check_eq("t6_c0_early", 64'(mem[18]), 64'd6);
    check_eq("t6_c1_early", 64'(mem[19]), 64'd12);
    check_eq("t6_c2_early", 64'(mem[20]), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 0, 0, 1'b0);
    check_run("t6");
    check_c("t6", c123);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
